// File: rtl/word_entry_unit_pkg.sv
// Shared constants and types for the nibble word entry unit and its button debouncer.
package word_entry_unit_pkg;

  typedef enum logic [1:0] {
    UP        = 2'd0,
    DOWN_WAIT = 2'd1,
    DOWN      = 2'd2,
    UP_WAIT   = 2'd3
  } dbState_t;

  localparam int NIBBLE_W         = 4;
  localparam int NIBBLES_PER_WORD = 8;
  localparam int WORD_W           = NIBBLE_W * NIBBLES_PER_WORD;
  localparam int COUNT_W          = 4;

  // Append one nibble at the least significant end; the oldest nibble falls off the top.
  function automatic logic [WORD_W-1:0] shiftIn(input logic [WORD_W-NIBBLE_W-1:0] low,
                                                input logic [NIBBLE_W-1:0] nib);
    return {low, nib};
  endfunction

endpackage

// File: rtl/word_entry_unit_if.sv
// Switch/button inputs and word outputs of the entry unit, grouped as one bus.
interface word_entry_unit_if;
  import word_entry_unit_pkg::*;

  logic [NIBBLE_W-1:0] sw_in;
  logic                enter_btn;
  logic                cancel;
  logic [WORD_W-1:0]   partial_out;
  logic [WORD_W-1:0]   word_out;
  logic [COUNT_W-1:0]  nibble_count;
  logic                word_valid;

  modport master (
    output sw_in, enter_btn, cancel,
    input  partial_out, word_out, nibble_count, word_valid
  );

  modport slave (
    input  sw_in, enter_btn, cancel,
    output partial_out, word_out, nibble_count, word_valid
  );

endinterface

// File: rtl/word_entry_unit_btn_debounce.sv
// Push-button debouncer: 2-flop synchronizer, four-state qualification FSM, one-cycle press strobe.
module btn_debounce
  import word_entry_unit_pkg::*;
#(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btnRaw,
  output logic press
);

  localparam int CNT_W = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic           btnMetaReg;
  logic           btnSyncReg;
  dbState_t       stateReg;
  dbState_t       stateNext;
  logic [CNT_W-1:0] cntReg;
  logic [CNT_W-1:0] cntNext;

  always_ff @(posedge clk) begin
    if (reset) begin
      btnMetaReg <= 1'b0;
      btnSyncReg <= 1'b0;
      stateReg   <= UP;
      cntReg     <= '0;
    end else begin
      btnMetaReg <= btnRaw;
      btnSyncReg <= btnMetaReg;
      stateReg   <= stateNext;
      cntReg     <= cntNext;
    end
  end

  // The counter stops at CNT_LAST because every path leaves the wait state there.
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    press     = 1'b0;
    case (stateReg)
      UP: begin
        if (btnSyncReg) begin
          stateNext = DOWN_WAIT;
          cntNext   = '0;
        end
      end
      DOWN_WAIT: begin
        if (!btnSyncReg) begin
          stateNext = UP;
        end else if (cntReg == CNT_LAST) begin
          stateNext = DOWN;
          press     = 1'b1;
        end else begin
          cntNext = cntReg + 1'b1;
        end
      end
      DOWN: begin
        if (!btnSyncReg) begin
          stateNext = UP_WAIT;
          cntNext   = '0;
        end
      end
      UP_WAIT: begin
        if (btnSyncReg) begin
          stateNext = DOWN;
        end else if (cntReg == CNT_LAST) begin
          stateNext = UP;
        end else begin
          cntNext = cntReg + 1'b1;
        end
      end
      default: begin
        stateNext = UP;
        cntNext   = '0;
      end
    endcase
  end

endmodule

// File: rtl/word_entry_unit.sv
// Assembles eight debounced nibble entries into a 32-bit word; cancel discards the partial word.
module word_entry_unit
  import word_entry_unit_pkg::*;
#(
  parameter int DB_CYCLES = 250000
) (
  input logic              clk,
  input logic              reset,
  word_entry_unit_if.slave bus
);

  localparam logic [COUNT_W-1:0] LAST_NIBBLE = COUNT_W'(NIBBLES_PER_WORD - 1);

  logic [NIBBLE_W-1:0] swMetaReg;
  logic [NIBBLE_W-1:0] swSyncReg;
  logic                cancelMetaReg;
  logic                cancelSyncReg;
  logic                press;

  logic [WORD_W-1:0]   partialReg;
  logic [WORD_W-1:0]   partialNext;
  logic [WORD_W-1:0]   wordReg;
  logic [WORD_W-1:0]   wordNext;
  logic [COUNT_W-1:0]  countReg;
  logic [COUNT_W-1:0]  countNext;
  logic                validReg;
  logic                validNext;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) uEnterDebounce (
    .clk   (clk),
    .reset (reset),
    .btnRaw(bus.enter_btn),
    .press (press)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      swMetaReg     <= '0;
      swSyncReg     <= '0;
      cancelMetaReg <= 1'b0;
      cancelSyncReg <= 1'b0;
      partialReg    <= '0;
      wordReg       <= '0;
      countReg      <= '0;
      validReg      <= 1'b0;
    end else begin
      swMetaReg     <= bus.sw_in;
      swSyncReg     <= swMetaReg;
      cancelMetaReg <= bus.cancel;
      cancelSyncReg <= cancelMetaReg;
      partialReg    <= partialNext;
      wordReg       <= wordNext;
      countReg      <= countNext;
      validReg      <= validNext;
    end
  end

  // Cancel has priority: a coincident press is dropped and no word completes.
  always_comb begin
    partialNext = partialReg;
    wordNext    = wordReg;
    countNext   = countReg;
    validNext   = 1'b0;
    if (cancelSyncReg) begin
      partialNext = '0;
      countNext   = '0;
    end else if (press) begin
      if (countReg == LAST_NIBBLE) begin
        wordNext    = shiftIn(partialReg[WORD_W-NIBBLE_W-1:0], swSyncReg);
        validNext   = 1'b1;
        partialNext = '0;
        countNext   = '0;
      end else begin
        partialNext = shiftIn(partialReg[WORD_W-NIBBLE_W-1:0], swSyncReg);
        countNext   = countReg + 1'b1;
      end
    end
  end

  assign bus.partial_out  = partialReg;
  assign bus.word_out     = wordReg;
  assign bus.nibble_count = countReg;
  assign bus.word_valid   = validReg;

endmodule

// File: tb/tb_word_entry_unit.sv
// Directed bench for word_entry_unit with DB_CYCLES=4: presses, bounce, cancel, coincidence, reset.
module tb_word_entry_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;
  int   wvCount;
  int   wvLong;
  int   lastWvCyc;
  logic prevWv;
  logic [31:0] lastWvWord;

  word_entry_unit_if bus();

  word_entry_unit #(
    .DB_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prevWv <= bus.word_valid;
    if (bus.word_valid) begin
      wvCount    <= wvCount + 1;
      lastWvCyc  <= cyc;
      lastWvWord <= bus.word_out;
      if (prevWv) wvLong <= wvLong + 1;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the button for 10 edges; the switches change after the load to prove they are ignored.
  task automatic pressNib(input logic [3:0] nib, input int cancelAt, output int startCyc);
    startCyc      = cyc;
    bus.sw_in     = nib;
    bus.enter_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      bus.cancel = (i == cancelAt);
      if (i == 8) bus.sw_in = ~nib;
      if (i == 10) bus.enter_btn = 1'b0;
    end
    bus.cancel = 1'b0;
    idle(12);
  endtask

  task automatic cancelPulse();
    bus.cancel = 1'b1;
    idle(1);
    bus.cancel = 1'b0;
    idle(4);
  endtask

  initial begin
    int s;
    int wvBase;
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    wvCount       = 0;
    wvLong        = 0;
    lastWvCyc     = -1;
    prevWv        = 1'b0;
    lastWvWord    = '0;
    reset         = 1'b1;
    bus.sw_in     = 4'h0;
    bus.enter_btn = 1'b0;
    bus.cancel    = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(2);
    checkVal("rst_partial", bus.partial_out, 32'h0);
    checkVal("rst_word", bus.word_out, 32'h0);
    checkVal("rst_count", {28'h0, bus.nibble_count}, 32'd0);
    checkVal("rst_valid", {31'h0, bus.word_valid}, 32'd0);

    // Clean press
    pressNib(4'hA, -1, s);
    checkVal("clean_partial", bus.partial_out, 32'h0000000A);
    checkVal("clean_count", {28'h0, bus.nibble_count}, 32'd1);

    // Bouncing press and release
    bus.sw_in = 4'hB;
    for (int i = 0; i < 4; i++) begin
      bus.enter_btn = (i % 2 == 0);
      idle(1);
    end
    bus.enter_btn = 1'b1;
    idle(10);
    for (int i = 0; i < 4; i++) begin
      bus.enter_btn = (i % 2 == 1);
      idle(1);
    end
    bus.enter_btn = 1'b0;
    idle(12);
    checkVal("bounce_partial", bus.partial_out, 32'h000000AB);
    checkVal("bounce_count", {28'h0, bus.nibble_count}, 32'd2);

    cancelPulse();
    checkVal("cancel1_count", {28'h0, bus.nibble_count}, 32'd0);

    // Full word 1..8
    for (int n = 1; n <= 8; n++) pressNib(4'(n), -1, s);
    checkVal("word_valid_pulses", wvCount, 32'd1);
    checkVal("word_valid_width", wvLong, 32'd0);
    checkVal("word_latency", lastWvCyc, s + 7);
    checkVal("word_at_valid", lastWvWord, 32'h12345678);
    checkVal("word_out", bus.word_out, 32'h12345678);
    checkVal("word_partial", bus.partial_out, 32'h0);
    checkVal("word_count", {28'h0, bus.nibble_count}, 32'd0);

    // Three nibbles then cancel
    pressNib(4'h9, -1, s);
    pressNib(4'hA, -1, s);
    pressNib(4'hB, -1, s);
    checkVal("three_partial", bus.partial_out, 32'h000009AB);
    checkVal("three_count", {28'h0, bus.nibble_count}, 32'd3);
    cancelPulse();
    checkVal("cancel_partial", bus.partial_out, 32'h0);
    checkVal("cancel_count", {28'h0, bus.nibble_count}, 32'd0);
    checkVal("cancel_word", bus.word_out, 32'h12345678);
    checkVal("cancel_no_valid", wvCount, 32'd1);

    // Seventh press strobe coincident with synchronized cancel
    for (int n = 1; n <= 6; n++) pressNib(4'(n), -1, s);
    checkVal("six_count", {28'h0, bus.nibble_count}, 32'd6);
    pressNib(4'h7, 4, s);
    checkVal("coinc_count", {28'h0, bus.nibble_count}, 32'd0);
    checkVal("coinc_partial", bus.partial_out, 32'h0);
    checkVal("coinc_word", bus.word_out, 32'h12345678);
    checkVal("coinc_no_valid", wvCount, 32'd1);

    // Reset mid DOWN_WAIT with button still held after release of reset
    pressNib(4'hC, -1, s);
    pressNib(4'hD, -1, s);
    checkVal("pre_rst_partial", bus.partial_out, 32'h000000CD);
    wvBase        = wvCount;
    bus.sw_in     = 4'hE;
    bus.enter_btn = 1'b1;
    idle(4);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2);
    bus.enter_btn = 1'b0;
    idle(15);
    checkVal("mrst_partial", bus.partial_out, 32'h0);
    checkVal("mrst_word", bus.word_out, 32'h0);
    checkVal("mrst_count", {28'h0, bus.nibble_count}, 32'd0);
    checkVal("mrst_valid", {31'h0, bus.word_valid}, 32'd0);
    checkVal("mrst_no_valid", wvCount, wvBase);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/word_entry_unit.md
WORD_ENTRY_UNIT -- requirements
Module: word_entry_unit

Interface
REQ-001 Parameter DB_CYCLES, default 250000, number of consecutive stable clk cycles required to accept a button level change (10 ms at 25 MHz).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sw_in  input  4  raw nibble switches, asynchronous to clk.
REQ-005 enter_btn  input  1  raw push button (bouncing, asynchronous); a debounced press loads one nibble.
REQ-006 cancel  input  1  raw level, asynchronous; discards the partial word.
REQ-007 partial_out  output  32  word under construction, for the display path.
REQ-008 word_out  output  32  last completed 8-nibble word.
REQ-009 nibble_count  output  4  nibbles loaded into the partial word, 0..7.
REQ-010 word_valid  output  1  one-cycle strobe when word_out updates.

Function
REQ-011 sw_in, enter_btn and cancel SHALL each pass through a 2-flop synchronizer before use; the synchronizer output is termed _s.
REQ-012 Debouncer FSM states SHALL be UP, DOWN_WAIT, DOWN, UP_WAIT.
REQ-013 UP: enter_btn_s=1 -> DOWN_WAIT, counter cleared to 0; otherwise stay.
REQ-014 DOWN_WAIT: enter_btn_s=0 -> UP; else counter increments; counter = DB_CYCLES-1 -> DOWN and generate one-cycle internal press strobe.
REQ-015 DOWN: enter_btn_s=0 -> UP_WAIT, counter cleared; otherwise stay (holding SHALL NOT repeat loads).
REQ-016 UP_WAIT: enter_btn_s=1 -> DOWN; else counter increments; counter = DB_CYCLES-1 -> UP.
REQ-017 Counter width SHALL be clog2(DB_CYCLES)+1 bits; the counter SHALL NOT wrap.
REQ-018 On press strobe, with nibble_count<7: partial_out <= {partial_out[27:0], sw_in_s}; nibble_count increments.
REQ-019 On press strobe, with nibble_count=7: word_out <= {partial_out[27:0], sw_in_s}; word_valid=1 on the next cycle only; partial_out <= 0; nibble_count <= 0.
REQ-020 Press-to-word_valid latency SHALL be exactly 1 cycle after the strobe cycle.
REQ-021 cancel_s=1 SHALL clear partial_out and nibble_count on the next edge; word_out SHALL be unaffected.
REQ-022 cancel_s and press strobe in the same cycle: cancel SHALL win; the nibble SHALL be dropped and word_valid SHALL stay 0.
REQ-023 sw_in_s SHALL be sampled in the strobe cycle; switch changes while the button is held SHALL have no effect.
REQ-024 word_out SHALL hold its value until the next completed word.

Reset
REQ-025 reset=1 SHALL, on the next clk edge: put the FSM in UP, counter=0, partial_out=0, word_out=0, nibble_count=0, word_valid=0, synchronizer flops=0.
REQ-026 Reset mid-debounce or mid-word SHALL discard all progress; a button still held at reset release SHALL need a full DOWN_WAIT qualification before loading.

Structure
REQ-027 The debouncer FSM state encoding and the NIBBLES_PER_WORD=8 constant SHALL live in the shared package.
REQ-028 The debouncer (synchronizer + FSM + counter, output = press strobe) SHALL be one sub-module, btn_debounce, reusable for the processor step button.
REQ-029 Assembly logic SHALL stay in word_entry_unit; total RTL 120-400 lines.

Verification (DB_CYCLES=4)
REQ-030 Clean press of 10 cycles with sw_in=4'hA -> exactly one load: partial_out=32'h0000000A, nibble_count=1.
REQ-031 Bounce 1,0,1,0 (1 cycle each) then stable 1 for 10 cycles -> exactly one load; release bounce -> no extra load.
REQ-032 Eight presses with sw_in=1..8 -> word_valid single-cycle pulse, word_out=32'h12345678, partial_out=0, nibble_count=0.
REQ-033 Three nibbles loaded, then cancel pulse -> partial_out=0, nibble_count=0, previous word_out unchanged, word_valid=0.
REQ-034 Seventh-press strobe coincident with cancel_s -> nibble dropped, counts=0; reset asserted mid-DOWN_WAIT -> all outputs 0 and no load on release.
